// File: rtl/alu_pkg.sv
// Shared constants and FSM state type for the ALU slice.
// ALU_MUL_EN selects op 7 = sequential MUL (defined) or LSR (undefined).
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;
  localparam logic [2:0] OP_LSR = 3'd7;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

`ifdef ALU_MUL_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;
`else
  typedef enum logic {ST_IDLE = 1'b0} state_t;
`endif

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier, one iteration per clock; only built with ALU_MUL_EN.
// product/done are combinational so the final partial sum lands on the last edge.
`ifdef ALU_MUL_EN
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               run;

  always_comb begin
    acc_next = mplier[0] ? acc + mcand : acc;
  end

  assign product = acc_next;
  assign done    = run && (cnt == CW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start && !run) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= CW'(WIDTH);
      run    <= 1'b1;
    end else if (run) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) run <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/alu_unit.sv
// 8-bit ALU with result/flags registers and tri-state bus drive.
// ALU_MUL_EN: op 7 is a multi-cycle MUL with busy; otherwise op 7 is LSR.
module alu_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_l,
  input  logic [WIDTH-1:0] alu_r,
  input  logic [2:0]       op,
  input  logic             calcn,
  input  logic             outn,
  inout  logic [WIDTH-1:0] bus,
  output logic [3:0]       flags,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, res_sc, res_d, rhs;
  logic [3:0]       flags_q, flags_d;
  logic [WIDTH:0]   sum;
  logic             cin, ovf, c_sc, v_sc, c_d, v_d, load;

`ifdef ALU_MUL_EN
  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (alu_l),
    .b       (alu_r),
    .product (mul_product),
    .done    (mul_done)
  );

  assign busy = (state_q == ST_MUL);
`else
  assign busy = 1'b0;
`endif

  // Subtraction reuses the adder with an inverted right operand, so V uses ~r.
  always_comb begin
    rhs = ((op == OP_SUB) || (op == OP_SBC)) ? ~alu_r : alu_r;
    case (op)
      OP_ADD:  cin = 1'b0;
      OP_SUB:  cin = 1'b1;
      default: cin = flags_q[FLAG_C];
    endcase
    sum = {1'b0, alu_l} + {1'b0, rhs} + {{WIDTH{1'b0}}, cin};
    ovf = (alu_l[WIDTH-1] == rhs[WIDTH-1]) && (sum[WIDTH-1] != alu_l[WIDTH-1]);

    res_sc = '0;
    c_sc   = 1'b0;
    v_sc   = 1'b0;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        res_sc = sum[WIDTH-1:0];
        c_sc   = sum[WIDTH];
        v_sc   = ovf;
      end
      OP_AND: res_sc = alu_l & alu_r;
      OP_OR:  res_sc = alu_l | alu_r;
      OP_XOR: res_sc = alu_l ^ alu_r;
      default: begin
`ifndef ALU_MUL_EN
        res_sc = alu_l >> 1;
        c_sc   = alu_l[0];
`endif
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    res_d   = res_sc;
    c_d     = c_sc;
    v_d     = v_sc;
`ifdef ALU_MUL_EN
    mul_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!calcn) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            load = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          load    = 1'b1;
          res_d   = mul_product[WIDTH-1:0];
          c_d     = |mul_product[2*WIDTH-1:WIDTH];
          v_d     = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase
`else
    if ((state_q == ST_IDLE) && !calcn) load = 1'b1;
`endif
  end

  always_comb begin
    flags_d         = '0;
    flags_d[FLAG_C] = c_d;
    flags_d[FLAG_Z] = (res_d == '0);
    flags_d[FLAG_N] = res_d[WIDTH-1];
    flags_d[FLAG_V] = v_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        result_q <= res_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign flags = flags_q;
  assign bus   = outn ? 'z : result_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed plus random bench for alu_unit against an arithmetic reference model.
// Works in both ALU_MUL_EN and default builds.
module tb_alu_unit;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] alu_l, alu_r;
  logic [2:0] op;
  logic       calcn, outn;
  wire  [7:0] bus;
  logic [3:0] flags;
  logic       busy;

  logic       drv_en;
  logic [7:0] drv_val;
  assign bus = drv_en ? drv_val : 8'bz;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_res;
  logic [3:0] m_flags;
  logic       busy_seen = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) if (busy === 1'b1) busy_seen <= 1'b1;

  alu_unit #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .alu_l (alu_l),
    .alu_r (alu_r),
    .op    (op),
    .calcn (calcn),
    .outn  (outn),
    .bus   (bus),
    .flags (flags),
    .busy  (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, C/V from true unsigned/signed ranges.
  task automatic model_op(input logic [2:0] o, input logic [7:0] l, input logic [7:0] r);
    int s, sv, sl, sr, ci;
    bit c, v;
    logic [7:0] res;
    sl = $signed(l);
    sr = $signed(r);
    ci = int'(m_flags[0]);
    c = 1'b0;
    v = 1'b0;
    s = 0;
    sv = 0;
    case (o)
      3'd0: begin s = l + r;        sv = sl + sr;        c = (s > 255); end
      3'd1: begin s = l + r + ci;   sv = sl + sr + ci;   c = (s > 255); end
      3'd2: begin s = l - r;        sv = sl - sr;        c = (s >= 0);  end
      3'd3: begin s = l - r - (1 - ci); sv = sl - sr - (1 - ci); c = (s >= 0); end
      3'd4: s = l & r;
      3'd5: s = l | r;
      3'd6: s = l ^ r;
      default: begin
`ifdef ALU_MUL_EN
        s = l * r;
        c = (s > 255);
`else
        s = l / 2;
        c = l[0];
`endif
      end
    endcase
    if (o <= 3'd3) v = (sv > 127) || (sv < -128);
    res = 8'(s & 255);
    m_res = res;
    m_flags = {v, res[7], (res == 8'd0), c};
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [7:0] l, input logic [7:0] r);
    int n;
    @(negedge clk);
    op = o; alu_l = l; alu_r = r; calcn = 1'b0;
    @(negedge clk);
    calcn = 1'b1;
    alu_l = 8'($urandom); alu_r = 8'($urandom);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) chk({tag, "_timeout"}, 32'(busy), 32'd0);
    model_op(o, l, r);
    chk({tag, "_res"}, 32'(bus), 32'(m_res));
    chk({tag, "_flags"}, 32'(flags), 32'(m_flags));
  endtask

  initial begin
    int n;
    logic [2:0] ro;
    reset = 1'b0; calcn = 1'b1; outn = 1'b0; op = '0;
    alu_l = '0; alu_r = '0; drv_en = 1'b0; drv_val = '0;
    m_res = '0; m_flags = '0;
    #12;
    chk("rst_bus", 32'(bus), 32'h00);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk) reset = 1'b1;

    do_op("add_cz", OP_ADD, 8'h3a, 8'hc6);
    chk("add_cz_const", {bus, flags}, {8'h00, 4'b0011});
    outn = 1'b1; drv_en = 1'b1; drv_val = 8'h55;
    #1 chk("bus_release", 32'(bus), 32'h55);
    drv_en = 1'b0; outn = 1'b0;
    #1 chk("bus_redrive", 32'(bus), 32'h00);

    do_op("add_ovf", OP_ADD, 8'h7f, 8'h01);
    chk("add_ovf_const", {bus, flags}, {8'h80, 4'b1100});
    do_op("adc_c0", OP_ADC, 8'h10, 8'h20);
    chk("adc_c0_const", 32'(bus), 32'h30);
    do_op("sub_eq", OP_SUB, 8'h3a, 8'h3a);
    chk("sub_eq_const", {bus, flags}, {8'h00, 4'b0011});
    do_op("adc_c1", OP_ADC, 8'h10, 8'h20);
    chk("adc_c1_const", 32'(bus), 32'h31);

    do_op("xor", OP_XOR, 8'hff, 8'h0f);
    chk("xor_const", {bus, flags}, {8'hf0, 4'b0100});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      alu_l = 8'($urandom); alu_r = 8'($urandom); op = 3'($urandom);
      chk("hold_res", 32'(bus), 32'hf0);
      chk("hold_flags", 32'(flags), 32'h4);
    end

`ifdef ALU_MUL_EN
    @(negedge clk);
    op = OP_MUL; alu_l = 8'h0d; alu_r = 8'h0b; calcn = 1'b0;
    @(negedge clk);
    calcn = 1'b1; alu_l = 8'hff; alu_r = 8'hff;
    chk("mul_busy_rise", 32'(busy), 32'h1);
    chk("mul_hold_res", 32'(bus), 32'hf0);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("mul_busy_len", 32'(n), 32'd8);
    model_op(OP_MUL, 8'h0d, 8'h0b);
    chk("mul_res", {bus, flags}, {m_res, m_flags});
    chk("mul_res_const", {bus, flags}, {8'h8f, 4'b0100});

    @(negedge clk);
    op = OP_MUL; alu_l = 8'h20; alu_r = 8'h10; calcn = 1'b0;
    @(negedge clk);
    calcn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    op = OP_ADD; alu_l = 8'h01; alu_r = 8'h01; calcn = 1'b0;
    @(negedge clk);
    calcn = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("mul2_done", 32'(busy), 32'h0);
    model_op(OP_MUL, 8'h20, 8'h10);
    chk("mul2_res", {bus, flags}, {m_res, m_flags});
    chk("mul2_const", {bus, flags}, {8'h00, 4'b0011});

    @(negedge clk);
    op = OP_MUL; alu_l = 8'h0d; alu_r = 8'h0b; calcn = 1'b0;
    @(negedge clk);
    calcn = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mulrst_busy", 32'(busy), 32'h0);
    chk("mulrst_res", {bus, flags}, {8'h00, 4'h0});
    @(negedge clk) reset = 1'b1;
    m_res = '0; m_flags = '0;
    repeat (12) @(negedge clk);
    chk("mulrst_late", {bus, flags, 3'b000, busy}, {8'h00, 4'h0, 4'h0});
`else
    do_op("lsr", OP_LSR, 8'h81, 8'h00);
    chk("lsr_const", {bus, flags}, {8'h40, 4'b0001});
    chk("lsr_busy", 32'(busy), 32'h0);
`endif

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      do_op("rand", ro, 8'($urandom), 8'($urandom));
    end

    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rst2_bus", 32'(bus), 32'h00);
    chk("rst2_flags", 32'(flags), 32'h0);
    chk("rst2_busy", 32'(busy), 32'h0);
    @(negedge clk) reset = 1'b1;

`ifndef ALU_MUL_EN
    chk("busy_never", 32'(busy_seen), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
